alu_muldiv: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle RV32I ALU: executes the base integer ops (funct7 = 0 / 32) and the M-extension ops (funct7 = 1) behind a start/busy/done handshake. Base ops complete in one cycle; MUL/DIV families use an iterative one-bit-per-cycle shift-add / restoring datapath. Sits in the execute stage between the register file read ports and writeback; the control unit holds the pipeline while `busy` is high.

---
 rtl/alu_pkg.sv | 62 ++++++
 rtl/alu_muldiv_core.sv | 134 +++++++++++++
 rtl/alu_muldiv.sv | 142 ++++++++++++++
 tb/tb_alu_muldiv.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
//==============================================================================
// Module      : alu_pkg
// Description : Shared constants, op encodings and FSM states for alu_muldiv.
// Revision    : 1.0 - initial release
//==============================================================================
package alu_pkg;

  localparam logic [6:0] F7_BASE   = 7'd0;
  localparam logic [6:0] F7_ALT    = 7'd32;
  localparam logic [6:0] F7_MULDIV = 7'd1;

  localparam logic [2:0] ALT_SUB = 3'd0;
  localparam logic [2:0] ALT_SRA = 3'd5;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SLL  = 3'd1,
    OP_SLT  = 3'd2,
    OP_SLTU = 3'd3,
    OP_XOR  = 3'd4,
    OP_SRL  = 3'd5,
    OP_OR   = 3'd6,
    OP_AND  = 3'd7
  } base_op_e;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic md_signed_a(input md_op_e op);
    return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic md_signed_b(input md_op_e op);
    return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
  endfunction

  function automatic logic md_is_div(input md_op_e op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic md_is_rem(input md_op_e op);
    return op inside {MD_REM, MD_REMU};
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_core.sv
`default_nettype none
//==============================================================================
// Module      : alu_muldiv_core
// Description : Iterative shift-add multiplier / restoring divider on magnitudes,
//               one shared XLEN+1 adder, step counter and final sign fixup.
// Revision    : 1.0 - initial release
//==============================================================================
module alu_muldiv_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            load,
  input  logic            run,
  input  md_op_e          op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            last,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  md_op_e            op_q, op_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic              neg_q, neg_d;
  logic [CW-1:0]     count_q, count_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              is_div;
  logic [XLEN:0]     shifted, add_a, add_b, sum;
  logic              add_cin;
  logic [2*XLEN-1:0] product, product_fix;
  logic [XLEN-1:0]   fixed;

  assign last   = (count_q == CW'(XLEN));
  assign result = result_q;

  always_comb begin
    a_neg  = md_signed_a(op) & rs1[XLEN-1];
    b_neg  = md_signed_b(op) & rs2[XLEN-1];
    mag_a  = a_neg ? -rs1 : rs1;
    mag_b  = b_neg ? -rs2 : rs2;
    is_div = md_is_div(op_q);

    // Divide: trial-subtract the divisor from the remainder shifted left by one.
    // Multiply: conditionally add the multiplicand into the high half.
    shifted = {hi_q, lo_q[XLEN-1]};
    if (is_div) begin
      add_a   = shifted;
      add_b   = ~{1'b0, opb_q};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, hi_q};
      add_b   = lo_q[0] ? {1'b0, opb_q} : '0;
      add_cin = 1'b0;
    end
    sum = add_a + add_b + {{XLEN{1'b0}}, add_cin};

    product     = {hi_q, lo_q};
    product_fix = neg_q ? -product : product;
    case (op_q)
      MD_MUL:                       fixed = product_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fixed = product_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              fixed = neg_q ? -lo_q : lo_q;
      default:                      fixed = neg_q ? -hi_q : hi_q;
    endcase
  end

  always_comb begin
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    count_d  = count_q;
    result_d = result_q;
    if (enable) begin
      if (load) begin
        op_d    = op;
        hi_d    = '0;
        lo_d    = mag_a;
        opb_d   = mag_b;
        neg_d   = md_is_rem(op) ? a_neg : (a_neg ^ b_neg);
        count_d = '0;
      end else if (run && !last) begin
        count_d = count_q + 1'b1;
        if (is_div) begin
          if (!sum[XLEN]) begin
            hi_d = sum[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = shifted[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          hi_d = sum[XLEN:1];
          lo_d = {sum[0], lo_q[XLEN-1:1]};
        end
      end else if (run && last) begin
        result_d = fixed;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q     <= MD_MUL;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_muldiv.sv
`default_nettype none
//==============================================================================
// Module      : alu_muldiv
// Description : RV32I/M execute unit: single-cycle base ALU plus iterative
//               MUL/DIV core behind a start/busy/done handshake.
// Revision    : 1.0 - initial release
//==============================================================================
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] register_data_1,
  input  logic [XLEN-1:0] register_data_2,
  output logic [XLEN-1:0] register_data_out,
  output logic            busy,
  output logic            done,
  output logic            illegal
);

  localparam int SW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            illegal_q, illegal_d;

  base_op_e        base_op;
  md_op_e          md_op;
  logic [SW-1:0]   shamt;
  logic            is_base, is_alt, is_md, div_zero, overflow, md_early, is_iter;
  logic            imm_illegal;
  logic [XLEN-1:0] imm_result;
  logic            core_load, core_run, core_last;
  logic [XLEN-1:0] core_result;

  alu_muldiv_core #(.XLEN(XLEN)) u_core (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .load   (core_load),
    .run    (core_run),
    .op     (md_op),
    .rs1    (register_data_1),
    .rs2    (register_data_2),
    .last   (core_last),
    .result (core_result)
  );

  always_comb begin
    base_op  = base_op_e'(funct3);
    md_op    = md_op_e'(funct3);
    shamt    = register_data_2[SW-1:0];
    is_base  = (funct7 == F7_BASE);
    is_alt   = (funct7 == F7_ALT) && (funct3 == ALT_SUB || funct3 == ALT_SRA);
    is_md    = (funct7 == F7_MULDIV);
    div_zero = (register_data_2 == '0);
    overflow = md_signed_a(md_op) && (register_data_1 == {1'b1, {(XLEN-1){1'b0}}})
               && (register_data_2 == '1);
    // Division corner cases resolve without iterating.
    md_early    = is_md && md_is_div(md_op) && (div_zero || overflow);
    is_iter     = is_md && !md_early;
    imm_illegal = !(is_base || is_alt || is_md);

    imm_result = '0;
    if (is_base) begin
      case (base_op)
        OP_ADD:  imm_result = register_data_1 + register_data_2;
        OP_SLL:  imm_result = register_data_1 << shamt;
        OP_SLT:  imm_result = {{(XLEN-1){1'b0}},
                               $signed(register_data_1) < $signed(register_data_2)};
        OP_SLTU: imm_result = {{(XLEN-1){1'b0}}, register_data_1 < register_data_2};
        OP_XOR:  imm_result = register_data_1 ^ register_data_2;
        OP_SRL:  imm_result = register_data_1 >> shamt;
        OP_OR:   imm_result = register_data_1 | register_data_2;
        default: imm_result = register_data_1 & register_data_2;
      endcase
    end else if (is_alt) begin
      if (funct3 == ALT_SUB) imm_result = register_data_1 - register_data_2;
      else                   imm_result = $signed(register_data_1) >>> shamt;
    end else if (md_early) begin
      if (div_zero) imm_result = md_is_rem(md_op) ? register_data_1 : '1;
      else          imm_result = md_is_rem(md_op) ? '0 : register_data_1;
    end
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    core_load = 1'b0;
    core_run  = (state_q == ST_BUSY);
    if (enable) begin
      illegal_d = 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_d = ST_IDLE;
          if (start) begin
            if (is_iter) begin
              state_d   = ST_BUSY;
              core_load = 1'b1;
            end else begin
              state_d   = ST_DONE;
              result_d  = imm_result;
              illegal_d = imm_illegal;
            end
          end
        end
        ST_BUSY: if (core_last) state_d = ST_FIX;
        ST_FIX: begin
          state_d  = ST_DONE;
          result_d = core_result;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign register_data_out = result_q;
  assign busy              = (state_q == ST_BUSY) || (state_q == ST_FIX);
  assign done              = (state_q == ST_DONE);
  assign illegal           = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
//==============================================================================
// Module      : tb_alu_muldiv
// Description : Scoreboard bench for alu_muldiv with directed and random ops.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_alu_muldiv;

  localparam int XLEN     = 32;
  localparam int ITER_LAT = XLEN + 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [31:0] data_out;
  logic        busy, done, illegal;

  alu_muldiv #(.XLEN(XLEN)) dut (
    .clock             (clock),
    .reset             (reset),
    .enable            (enable),
    .start             (start),
    .funct3            (funct3),
    .funct7            (funct7),
    .register_data_1   (rs1),
    .register_data_2   (rs2),
    .register_data_out (data_out),
    .busy              (busy),
    .done              (done),
    .illegal           (illegal)
  );

  always #5 clock = ~clock;

  int   cyc = 0;
  logic en_edge = 1'b0;
  always @(posedge clock) begin
    cyc     <= cyc + 1;
    en_edge <= enable;
  end

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
    int          acc;
    int          id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   next_id = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic fail_now(input string msg);
    checks++;
    errors++;
    $display("FAIL %s", msg);
  endtask

  // Reference model: architectural result straight from the ISA definitions.
  function automatic logic [32:0] model(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        ill;
    longint      sa, sbv, ua, ub, q;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    ill = 1'b0;
    case (f7)
      7'd0: case (f3)
        3'd0: r = a + b;
        3'd1: r = a << b[4:0];
        3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: r = a >> b[4:0];
        3'd6: r = a | b;
        default: r = a & b;
      endcase
      7'd32: begin
        if (f3 == 3'd0)      r = a - b;
        else if (f3 == 3'd5) r = $signed(a) >>> b[4:0];
        else                 ill = 1'b1;
      end
      7'd1: case (f3)
        3'd0: begin p = sa * sbv; r = p[31:0];  end
        3'd1: begin p = sa * sbv; r = p[63:32]; end
        3'd2: begin p = sa * ub;  r = p[63:32]; end
        3'd3: begin p = ua * ub;  r = p[63:32]; end
        3'd4: begin
          if (b == 0) r = '1;
          else if (ovf) r = a;
          else begin q = sa / sbv; r = q[31:0]; end
        end
        3'd5: r = (b == 0) ? '1 : a / b;
        3'd6: begin
          if (b == 0) r = a;
          else if (ovf) r = '0;
          else begin q = sa % sbv; r = q[31:0]; end
        end
        default: r = (b == 0) ? a : a % b;
      endcase
      default: ill = 1'b1;
    endcase
    return {ill, r};
  endfunction

  function automatic int model_lat(input logic [6:0] f7, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] b);
    if (f7 != 7'd1) return 0;
    if (f3 >= 3'd4 && b == 0) return 0;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return ITER_LAT;
  endfunction

  task automatic scramble();
    rs1    = $urandom;
    rs2    = $urandom;
    funct3 = 3'($urandom);
    funct7 = 7'($urandom);
  endtask

  // Drives one request at the next free negedge; start is left high so a
  // following call lands back-to-back while the DUT sits in DONE.
  task automatic issue(input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic ill, input int lat);
    int budget;
    budget = 0;
    @(negedge clock);
    while (busy && budget < 200) begin
      start = 1'b0;
      scramble();
      budget++;
      @(negedge clock);
    end
    if (busy) begin
      fail_now($sformatf("issue_timeout id=%0d busy=1 required 0", next_id));
    end else begin
      start  = 1'b1;
      funct7 = f7;
      funct3 = f3;
      rs1    = a;
      rs2    = b;
      @(posedge clock);
      #1;
      sb.push_back('{res: res, ill: ill, lat: lat, acc: cyc, id: next_id});
      next_id++;
    end
  endtask

  task automatic iss(input logic [6:0] f7, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] b);
    logic [32:0] m;
    m = model(f7, f3, a, b);
    issue(f7, f3, a, b, m[31:0], m[32], model_lat(f7, f3, a, b));
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    @(negedge clock);
    start = 1'b0;
    scramble();
    while (sb.size() > 0 && budget < 500) begin
      budget++;
      @(negedge clock);
    end
    if (sb.size() > 0) begin
      fail_now($sformatf("drain_timeout pending=%0d required 0", sb.size()));
      sb.delete();
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [6:0] pick_f7();
    case ($urandom_range(0, 5))
      0: return 7'd0;
      1: return 7'd32;
      2, 3, 4: return 7'd1;
      default: return 7'($urandom);
    endcase
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      check("busy_and_done", {31'b0, busy & done}, 32'd0);
      if (done && en_edge) begin
        if (sb.size() == 0) begin
          fail_now($sformatf("unexpected_done result=%h required no completion", data_out));
        end else begin
          mon_e = sb.pop_front();
          check($sformatf("result id=%0d", mon_e.id), data_out, mon_e.res);
          check($sformatf("illegal id=%0d", mon_e.id), {31'b0, illegal}, {31'b0, mon_e.ill});
          check($sformatf("latency id=%0d", mon_e.id), 32'(cyc - mon_e.acc), 32'(mon_e.lat));
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out"},     data_out, 32'd0);
    check({tag, "_busy"},    {31'b0, busy}, 32'd0);
    check({tag, "_done"},    {31'b0, done}, 32'd0);
    check({tag, "_illegal"}, {31'b0, illegal}, 32'd0);
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 check_reset_outputs("reset");
    @(negedge clock);
    #1 reset = 1'b0;

    // Base ops, back-to-back
    issue(7'd0,  3'd0, 32'd1, 32'd2, 32'd3, 1'b0, 0);
    issue(7'd32, 3'd0, 32'd1, 32'd2, 32'hFFFF_FFFF, 1'b0, 0);
    issue(7'd32, 3'd5, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 0);
    issue(7'd0,  3'd2, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 0);
    issue(7'd0,  3'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 0);
    // Multiplies
    issue(7'd1, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, ITER_LAT);
    issue(7'd1, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, ITER_LAT);
    issue(7'd1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, ITER_LAT);
    issue(7'd1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, ITER_LAT);
    // Divides
    issue(7'd1, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, ITER_LAT);
    issue(7'd1, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, ITER_LAT);
    issue(7'd1, 3'd5, 32'd100, 32'd7, 32'd14, 1'b0, ITER_LAT);
    issue(7'd1, 3'd7, 32'd100, 32'd7, 32'd2, 1'b0, ITER_LAT);
    // Division corner cases complete immediately
    issue(7'd1, 3'd4, 32'd1234, 32'd0, 32'hFFFF_FFFF, 1'b0, 0);
    issue(7'd1, 3'd7, 32'd5, 32'd0, 32'd5, 1'b0, 0);
    issue(7'd1, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0);
    issue(7'd1, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
    // Illegal encodings
    issue(7'd2,  3'd0, 32'd9, 32'd9, 32'd0, 1'b1, 0);
    issue(7'd32, 3'd1, 32'd9, 32'd9, 32'd0, 1'b1, 0);
    wait_idle();

    // Start pulses while busy must be ignored
    issue(7'd1, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, ITER_LAT);
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      if (!busy) break;
      start  = 1'b1;
      funct7 = 7'd0;
      funct3 = 3'd0;
      rs1    = $urandom;
      rs2    = $urandom;
    end
    start = 1'b0;
    wait_idle();

    // Five stalled cycles in the middle of a multiply
    issue(7'd1, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, ITER_LAT + 5);
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    enable = 1'b0;
    repeat (5) @(negedge clock);
    enable = 1'b1;
    wait_idle();

    // done holds through a stall
    issue(7'd0, 3'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0, 0);
    enable = 1'b0;
    start  = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("done_held_in_stall", {31'b0, done}, 32'd1);
    end
    enable = 1'b1;
    wait_idle();

    // Asynchronous reset mid-divide, then a normal op
    issue(7'd1, 3'd5, 32'd100, 32'd7, 32'd14, 1'b0, ITER_LAT);
    start = 1'b0;
    repeat (10) @(posedge clock);
    #2 reset = 1'b1;
    #1 check_reset_outputs("abort");
    sb.delete();
    @(negedge clock);
    #1 reset = 1'b0;
    issue(7'd0, 3'd0, 32'd5, 32'd6, 32'd11, 1'b0, 0);
    wait_idle();

    // Randomized ops against the model
    for (int n = 0; n < 120; n++) begin
      iss(pick_f7(), 3'($urandom), pick(), pick());
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
